// File: rtl/tx_arbiter.sv
// tx_arbiter: shares the ring TX serializer, ctrl first then round-robin fwd/node; optional TX_TIMEOUT_EN aborts a stuck WAIT_DONE.
// Latency: eligible request -> grant, select and tx_start one cycle later; grant held until tx_done (or abort).
// Backpressure: no arbitration while tx_ready is low; requests simply wait, nothing is dropped.
module tx_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter bit          NODE_FIRST     = 1'b0
) (
  input  logic       Clk_R,
  input  logic       Rst_R,
  input  logic       ctrl_req,
  input  logic       fwd_req,
  input  logic       node_req,
  input  logic       have_token,
  input  logic       tx_ready,
  input  logic       tx_done,
  output logic       ctrl_gnt,
  output logic       fwd_gnt,
  output logic       node_gnt,
  output logic       tx_start,
  output logic [1:0] tx_data_select,
  output logic       tx_busy,
  output logic       tx_timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    START     = 2'b01,
    WAIT_DONE = 2'b10
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_CTRL = 2'b01;
  localparam logic [1:0] SEL_FWD  = 2'b10;
  localparam logic [1:0] SEL_NODE = 2'b11;

  if (TIMEOUT_CYCLES < 2) begin : g_cfg_chk
    $error("tx_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  state_t     state_q, state_d;
  logic [1:0] sel_q, sel_d;
  logic       rr_q, rr_d;        // 1: node preferred on a fwd/node tie
  logic       ctrl_elig, fwd_elig, node_elig, any_elig;
  logic [1:0] win_sel;
  logic       xfer_end;
  logic       timeout_hit;

  assign ctrl_elig = ctrl_req;
  assign fwd_elig  = fwd_req;
  assign node_elig = node_req & have_token;
  assign any_elig  = ctrl_elig | fwd_elig | node_elig;

  always_comb begin
    win_sel = SEL_NONE;
    if (ctrl_elig) begin
      win_sel = SEL_CTRL;
    end else if (fwd_elig && node_elig) begin
      win_sel = rr_q ? SEL_NODE : SEL_FWD;
    end else if (fwd_elig) begin
      win_sel = SEL_FWD;
    end else if (node_elig) begin
      win_sel = SEL_NODE;
    end
  end

`ifdef TX_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Held at zero outside a transfer so it starts from zero in START.
  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (state_q == WAIT_DONE) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge Clk_R or posedge Rst_R) begin
    if (Rst_R) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (state_q == WAIT_DONE) && (cnt_q == CNT_LAST);
  assign tx_timeout  = timeout_hit & ~tx_done;
`else
  assign timeout_hit = 1'b0;
  assign tx_timeout  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    rr_d     = rr_q;
    xfer_end = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_ready && any_elig) begin
          state_d = START;
          sel_d   = win_sel;
        end
      end
      START: begin
        if (tx_done) begin
          xfer_end = 1'b1;
        end else begin
          state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (tx_done || timeout_hit) begin
          xfer_end = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        sel_d   = SEL_NONE;
      end
    endcase
    // Pointer moves to the requester that was not just served; ctrl leaves it alone.
    if (xfer_end) begin
      state_d = IDLE;
      sel_d   = SEL_NONE;
      if (sel_q == SEL_FWD) begin
        rr_d = 1'b1;
      end else if (sel_q == SEL_NODE) begin
        rr_d = 1'b0;
      end
    end
  end

  always_ff @(posedge Clk_R or posedge Rst_R) begin
    if (Rst_R) begin
      state_q <= IDLE;
      sel_q   <= SEL_NONE;
      rr_q    <= NODE_FIRST;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
    end
  end

  assign ctrl_gnt       = (sel_q == SEL_CTRL);
  assign fwd_gnt        = (sel_q == SEL_FWD);
  assign node_gnt       = (sel_q == SEL_NODE);
  assign tx_data_select = sel_q;
  assign tx_start       = (state_q == START);
  assign tx_busy        = (state_q != IDLE);

  a_gnt_onehot : assert property (@(posedge Clk_R) disable iff (Rst_R)
    $onehot0({ctrl_gnt, fwd_gnt, node_gnt}));
  a_start_single : assert property (@(posedge Clk_R) disable iff (Rst_R)
    tx_start |=> !tx_start);
  a_busy_has_gnt : assert property (@(posedge Clk_R) disable iff (Rst_R)
    tx_busy |-> (tx_data_select != SEL_NONE));

endmodule

// File: tb/tb_tx_arbiter.sv
// Directed bench for tx_arbiter: reset, priority, round-robin order, token gating, tx_ready hold-off, async reset, timeout.
module tb_tx_arbiter;

  logic       Clk_R;
  logic       Rst_R;
  logic       ctrl_req, fwd_req, node_req, have_token, tx_ready, tx_done;
  logic       ctrl_gnt, fwd_gnt, node_gnt, tx_start, tx_busy, tx_timeout;
  logic [1:0] tx_data_select;

  int vec_cnt = 0;
  int err_cnt = 0;

  tx_arbiter #(
    .TIMEOUT_CYCLES (16),
    .NODE_FIRST     (1'b0)
  ) dut (
    .Clk_R          (Clk_R),
    .Rst_R          (Rst_R),
    .ctrl_req       (ctrl_req),
    .fwd_req        (fwd_req),
    .node_req       (node_req),
    .have_token     (have_token),
    .tx_ready       (tx_ready),
    .tx_done        (tx_done),
    .ctrl_gnt       (ctrl_gnt),
    .fwd_gnt        (fwd_gnt),
    .node_gnt       (node_gnt),
    .tx_start       (tx_start),
    .tx_data_select (tx_data_select),
    .tx_busy        (tx_busy),
    .tx_timeout     (tx_timeout)
  );

  initial begin
    Clk_R = 1'b0;
    forever #5 Clk_R = ~Clk_R;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1, "watchdog expired");
  end

  task automatic check_vec(input string tag, input int got, input int exp);
    vec_cnt++;
    if (got != exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk_R);
    #1;
  endtask

  // Grants packed as {ctrl, fwd, node}: ctrl=4, fwd=2, node=1.
  function automatic int gnt_vec();
    return int'({ctrl_gnt, fwd_gnt, node_gnt});
  endfunction

  task automatic wait_start(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (tx_start) seen = 1'b1;
    end
  endtask

  // One transfer with tx_done three cycles after tx_start; returns the select seen at start.
  task automatic run_xfer(output int sel);
    bit seen;
    wait_start(seen);
    sel = seen ? int'(tx_data_select) : 0;
    tick();
    tick();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  initial begin
    int s;
    bit seen;
    int any_seen;
    int k;
    int exp_rr [4];
    exp_rr[0] = 2; exp_rr[1] = 3; exp_rr[2] = 2; exp_rr[3] = 3;

    Rst_R = 1'b1;
    ctrl_req = 1'b0; fwd_req = 1'b0; node_req = 1'b0;
    have_token = 1'b0; tx_ready = 1'b0; tx_done = 1'b0;
    tick();
    tick();
    check_vec("rst_gnt",     gnt_vec(), 0);
    check_vec("rst_sel",     int'(tx_data_select), 0);
    check_vec("rst_start",   int'(tx_start), 0);
    check_vec("rst_busy",    int'(tx_busy), 0);
    check_vec("rst_timeout", int'(tx_timeout), 0);
    Rst_R = 1'b0;
    tick();

    // Single ctrl transfer
    ctrl_req = 1'b1;
    tx_ready = 1'b1;
    tick();
    check_vec("ctrl_gnt",   gnt_vec(), 4);
    check_vec("ctrl_sel",   int'(tx_data_select), 1);
    check_vec("ctrl_start", int'(tx_start), 1);
    ctrl_req = 1'b0;
    tick();
    check_vec("ctrl_start_pulse", int'(tx_start), 0);
    check_vec("ctrl_busy",        int'(tx_busy), 1);
    repeat (3) tick();
    check_vec("ctrl_hold", gnt_vec(), 4);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_vec("ctrl_done_gnt",  gnt_vec(), 0);
    check_vec("ctrl_done_sel",  int'(tx_data_select), 0);
    check_vec("ctrl_done_busy", int'(tx_busy), 0);

    // fwd/node round robin, both held
    fwd_req = 1'b1; node_req = 1'b1; have_token = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run_xfer(s);
      check_vec("rr_order", s, exp_rr[i]);
      check_vec("rr_gap",   int'(tx_data_select), 0);
    end

    // ctrl first, then fwd/node order unaffected
    ctrl_req = 1'b1;
    run_xfer(s);
    check_vec("prio_ctrl", s, 1);
    ctrl_req = 1'b0;
    run_xfer(s);
    check_vec("prio_fwd", s, 2);
    run_xfer(s);
    check_vec("prio_node", s, 3);
    fwd_req = 1'b0; node_req = 1'b0;
    tick();

    // node gated by have_token
    node_req = 1'b1; have_token = 1'b0;
    any_seen = 0;
    repeat (20) begin
      tick();
      if (gnt_vec() != 0 || tx_busy) any_seen = 1;
    end
    check_vec("no_token", any_seen, 0);
    have_token = 1'b1;
    tick();
    check_vec("token_gnt",   gnt_vec(), 1);
    check_vec("token_start", int'(tx_start), 1);
    have_token = 1'b0; node_req = 1'b0;
    repeat (3) tick();
    check_vec("token_drop_hold", gnt_vec(), 1);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_vec("token_done", gnt_vec(), 0);

    // tx_done during START ends the transfer
    fwd_req = 1'b1;
    tick();
    check_vec("sd_start", int'(tx_start), 1);
    check_vec("sd_sel",   int'(tx_data_select), 2);
    fwd_req = 1'b0;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_vec("sd_busy", int'(tx_busy), 0);
    check_vec("sd_gnt",  gnt_vec(), 0);
    tick();

    // tx_ready low blocks arbitration; tx_done in IDLE ignored
    tx_ready = 1'b0;
    fwd_req = 1'b1;
    any_seen = 0;
    repeat (6) begin
      tick();
      if (gnt_vec() != 0 || tx_busy) any_seen = 1;
    end
    check_vec("not_ready", any_seen, 0);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_vec("idle_done_busy", int'(tx_busy), 0);
    check_vec("idle_done_sel",  int'(tx_data_select), 0);
    tx_ready = 1'b1;
    tick();
    check_vec("ready_gnt", gnt_vec(), 2);
    tick();
    check_vec("wait_busy", int'(tx_busy), 1);

    // async reset in WAIT_DONE
    Rst_R = 1'b1;
    #1;
    check_vec("arst_gnt",   gnt_vec(), 0);
    check_vec("arst_sel",   int'(tx_data_select), 0);
    check_vec("arst_busy",  int'(tx_busy), 0);
    check_vec("arst_start", int'(tx_start), 0);
    fwd_req = 1'b0;
    tick();
    Rst_R = 1'b0;
    tick();

    // pointer back to fwd-first after reset
    fwd_req = 1'b1; node_req = 1'b1; have_token = 1'b1;
    run_xfer(s);
    check_vec("rst_ptr_fwd", s, 2);
    run_xfer(s);
    check_vec("rst_ptr_node", s, 3);
    fwd_req = 1'b0; node_req = 1'b0;
    tick();

`ifdef TX_TIMEOUT_EN
    fwd_req = 1'b1;
    wait_start(seen);
    check_vec("to_started", int'(seen), 1);
    fwd_req = 1'b0;
    k = 0;
    for (int i = 0; i < 40 && !tx_timeout; i++) begin
      tick();
      k++;
    end
    check_vec("to_cycles", k, 16);
    check_vec("to_gnt_at_pulse", gnt_vec(), 2);
    tick();
    check_vec("to_pulse_width", int'(tx_timeout), 0);
    check_vec("to_gnt_drop",    gnt_vec(), 0);
    check_vec("to_busy",        int'(tx_busy), 0);

    fwd_req = 1'b1;
    wait_start(seen);
    fwd_req = 1'b0;
    repeat (16) tick();
    tx_done = 1'b1;
    #1;
    check_vec("to_done_wins", int'(tx_timeout), 0);
    check_vec("to_done_busy", int'(tx_busy), 1);
    tick();
    tx_done = 1'b0;
    check_vec("to_done_end",  gnt_vec(), 0);
    check_vec("to_done_none", int'(tx_timeout), 0);
`else
    fwd_req = 1'b1;
    wait_start(seen);
    check_vec("nto_started", int'(seen), 1);
    fwd_req = 1'b0;
    any_seen = 0;
    repeat (40) begin
      tick();
      if (tx_timeout) any_seen = 1;
    end
    check_vec("nto_no_pulse", any_seen, 0);
    check_vec("nto_hold",     gnt_vec(), 2);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check_vec("nto_end", gnt_vec(), 0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
